// File: rtl/major_cycle_sequencer.sv
// rtl/major_cycle_sequencer.sv - FETCH/DEFER/EXEC major-cycle sequencer
//
// Steps the memory-reference datapath through FETCH, DEFER and EXEC.
// Every state is made of two-clock steps: a ck clock, then a stb clock.
// All outputs come straight from flops. Each one is loaded with the value
// that belongs to the state being entered on that edge.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   run_req             one-clock start pulse, honoured only in HALT
//   halt_req, sstep     instruction-boundary halt controls (levels)
//   ramd[11:0]          RAM read data; decoded on the FETCH stb clock
//   done                end of instruction from the decoder, EXEC only
//   running             high outside HALT
//   ck[5:0], stb[5:0]   EXEC step clock phases and strobes
//   inst_is_dir/ind/ppind  addressing-mode flags
//   fetch_*             FETCH datapath controls
//   defer_*             DEFER datapath controls
//   exec_err            sticky EXEC timeout flag

module major_cycle_sequencer #(
  parameter int MAX_STEPS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_req,
  input  logic        halt_req,
  input  logic        sstep,
  input  logic [11:0] ramd,
  input  logic        done,
  output logic        running,
  output logic [5:0]  ck,
  output logic [5:0]  stb,
  output logic        inst_is_dir,
  output logic        inst_is_ind,
  output logic        inst_is_ppind,
  output logic        fetch_pc2rama,
  output logic        fetch_ram_oe,
  output logic        fetch_ir_ck,
  output logic        fetch_pc_ck,
  output logic        defer_ir2rama,
  output logic        defer_ram_oe,
  output logic        defer_ld2inc,
  output logic        defer_inc2ramd,
  output logic        defer_ram_we,
  output logic        defer_ind_ck,
  output logic        exec_err
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DEFER = 2'd2,
    ST_EXEC  = 2'd3
  } state_e;

  localparam logic [2:0] LAST_STEP = 3'(MAX_STEPS);

  // Sequencing state
  state_e     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic       half_q, half_d;      // 0 = ck clock, 1 = stb clock of the step

  // Mode flags and sticky error
  logic dir_q, dir_d;
  logic ind_q, ind_d;
  logic ppind_q, ppind_d;
  logic err_q, err_d;

  // Registered outputs
  logic       running_q, running_d;
  logic [5:0] ck_q, ck_d;
  logic [5:0] stb_q, stb_d;
  logic       f_pc2rama_q, f_pc2rama_d;
  logic       f_ram_oe_q, f_ram_oe_d;
  logic       f_ir_ck_q, f_ir_ck_d;
  logic       f_pc_ck_q, f_pc_ck_d;
  logic       d_ir2rama_q, d_ir2rama_d;
  logic       d_ram_oe_q, d_ram_oe_d;
  logic       d_ld2inc_q, d_ld2inc_d;
  logic       d_inc2ramd_q, d_inc2ramd_d;
  logic       d_ram_we_q, d_ram_we_d;
  logic       d_ind_ck_q, d_ind_ck_d;

  // Instruction decode of the word on ramd
  logic dec_dir, dec_ind, dec_ppind;
  logic autoindex;

  // Autoindex locations are page-zero 0010..0017.
  assign autoindex = !ramd[7] && (ramd[6:0] >= 7'o10) && (ramd[6:0] <= 7'o17);

  always_comb begin
    dec_dir   = 1'b0;
    dec_ind   = 1'b0;
    dec_ppind = 1'b0;
    if (ramd[11:9] < 3'd6) begin
      if (!ramd[8]) begin
        dec_dir = 1'b1;
      end else if (autoindex) begin
        dec_ppind = 1'b1;
      end else begin
        dec_ind = 1'b1;
      end
    end
  end

  // Next-state logic
  logic exec_exit;
  logic exec_timeout;
  logic go_halt;

  // An EXEC exit is either done or the stb clock of the last allowed step.
  assign exec_timeout = half_q && (step_q == LAST_STEP) && !done;
  assign exec_exit    = done || exec_timeout;
  assign go_halt      = halt_req || (sstep && !run_req);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    half_d  = half_q;
    dir_d   = dir_q;
    ind_d   = ind_q;
    ppind_d = ppind_q;
    err_d   = err_q;

    case (state_q)
      ST_HALT: begin
        step_d = 3'd0;
        half_d = 1'b0;
        if (run_req) begin
          state_d = ST_FETCH;
          step_d  = 3'd1;
        end
      end

      ST_FETCH: begin
        if (!half_q) begin
          half_d = 1'b1;
        end else begin
          dir_d   = dec_dir;
          ind_d   = dec_ind;
          ppind_d = dec_ppind;
          step_d  = 3'd1;
          half_d  = 1'b0;
          state_d = (dec_ind || dec_ppind) ? ST_DEFER : ST_EXEC;
        end
      end

      ST_DEFER: begin
        if (!half_q) begin
          half_d = 1'b1;
        end else if ((step_q == 3'd1) && ppind_q) begin
          // Autoindex needs the extra read-increment-write step.
          step_d = 3'd2;
          half_d = 1'b0;
        end else begin
          state_d = ST_EXEC;
          step_d  = 3'd1;
          half_d  = 1'b0;
        end
      end

      ST_EXEC: begin
        if (exec_exit) begin
          if (exec_timeout) begin
            err_d = 1'b1;
          end
          half_d = 1'b0;
          if (go_halt) begin
            state_d = ST_HALT;
            step_d  = 3'd0;
          end else begin
            state_d = ST_FETCH;
            step_d  = 3'd1;
          end
        end else if (!half_q) begin
          half_d = 1'b1;
        end else begin
          step_d = step_q + 3'd1;
          half_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_HALT;
        step_d  = 3'd0;
        half_d  = 1'b0;
      end
    endcase
  end

  // Output values for the state being entered. Registering these keeps
  // every output glitch-free and aligned with the state it belongs to.
  always_comb begin
    running_d    = (state_d != ST_HALT);
    ck_d         = 6'd0;
    stb_d        = 6'd0;
    f_pc2rama_d  = 1'b0;
    f_ram_oe_d   = 1'b0;
    f_ir_ck_d    = 1'b0;
    f_pc_ck_d    = 1'b0;
    d_ir2rama_d  = 1'b0;
    d_ram_oe_d   = 1'b0;
    d_ld2inc_d   = 1'b0;
    d_inc2ramd_d = 1'b0;
    d_ram_we_d   = 1'b0;
    d_ind_ck_d   = 1'b0;

    case (state_d)
      ST_FETCH: begin
        f_pc2rama_d = 1'b1;
        f_ram_oe_d  = 1'b1;
        f_ir_ck_d   = half_d;
        f_pc_ck_d   = half_d;
      end

      ST_DEFER: begin
        d_ir2rama_d = 1'b1;
        if (step_d == 3'd1) begin
          d_ram_oe_d = 1'b1;
          d_ind_ck_d = half_d && ind_d;
          d_ld2inc_d = half_d && ppind_d;
        end else begin
          d_inc2ramd_d = 1'b1;
          d_ram_we_d   = half_d;
          d_ind_ck_d   = half_d;
        end
      end

      ST_EXEC: begin
        for (int i = 0; i < 6; i++) begin
          if (step_d == 3'(i + 1)) begin
            ck_d[i]  = 1'b1;
            stb_d[i] = half_d;
          end
        end
      end

      default: begin
        running_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_HALT;
      step_q       <= 3'd0;
      half_q       <= 1'b0;
      dir_q        <= 1'b0;
      ind_q        <= 1'b0;
      ppind_q      <= 1'b0;
      err_q        <= 1'b0;
      running_q    <= 1'b0;
      ck_q         <= 6'd0;
      stb_q        <= 6'd0;
      f_pc2rama_q  <= 1'b0;
      f_ram_oe_q   <= 1'b0;
      f_ir_ck_q    <= 1'b0;
      f_pc_ck_q    <= 1'b0;
      d_ir2rama_q  <= 1'b0;
      d_ram_oe_q   <= 1'b0;
      d_ld2inc_q   <= 1'b0;
      d_inc2ramd_q <= 1'b0;
      d_ram_we_q   <= 1'b0;
      d_ind_ck_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      half_q       <= half_d;
      dir_q        <= dir_d;
      ind_q        <= ind_d;
      ppind_q      <= ppind_d;
      err_q        <= err_d;
      running_q    <= running_d;
      ck_q         <= ck_d;
      stb_q        <= stb_d;
      f_pc2rama_q  <= f_pc2rama_d;
      f_ram_oe_q   <= f_ram_oe_d;
      f_ir_ck_q    <= f_ir_ck_d;
      f_pc_ck_q    <= f_pc_ck_d;
      d_ir2rama_q  <= d_ir2rama_d;
      d_ram_oe_q   <= d_ram_oe_d;
      d_ld2inc_q   <= d_ld2inc_d;
      d_inc2ramd_q <= d_inc2ramd_d;
      d_ram_we_q   <= d_ram_we_d;
      d_ind_ck_q   <= d_ind_ck_d;
    end
  end

  assign running        = running_q;
  assign ck             = ck_q;
  assign stb            = stb_q;
  assign inst_is_dir    = dir_q;
  assign inst_is_ind    = ind_q;
  assign inst_is_ppind  = ppind_q;
  assign fetch_pc2rama  = f_pc2rama_q;
  assign fetch_ram_oe   = f_ram_oe_q;
  assign fetch_ir_ck    = f_ir_ck_q;
  assign fetch_pc_ck    = f_pc_ck_q;
  assign defer_ir2rama  = d_ir2rama_q;
  assign defer_ram_oe   = d_ram_oe_q;
  assign defer_ld2inc   = d_ld2inc_q;
  assign defer_inc2ramd = d_inc2ramd_q;
  assign defer_ram_we   = d_ram_we_q;
  assign defer_ind_ck   = d_ind_ck_q;
  assign exec_err       = err_q;

endmodule

// File: tb/tb_major_cycle_sequencer.sv
// tb/tb_major_cycle_sequencer.sv - randomized self-checking bench for major_cycle_sequencer

module tb_major_cycle_sequencer;

  localparam int MAX_STEPS = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_req;
  logic        halt_req;
  logic        sstep;
  logic [11:0] ramd;
  logic        done;
  logic        running;
  logic [5:0]  ck;
  logic [5:0]  stb;
  logic        inst_is_dir, inst_is_ind, inst_is_ppind;
  logic        fetch_pc2rama, fetch_ram_oe, fetch_ir_ck, fetch_pc_ck;
  logic        defer_ir2rama, defer_ram_oe, defer_ld2inc;
  logic        defer_inc2ramd, defer_ram_we, defer_ind_ck;
  logic        exec_err;

  major_cycle_sequencer #(.MAX_STEPS(MAX_STEPS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .run_req        (run_req),
    .halt_req       (halt_req),
    .sstep          (sstep),
    .ramd           (ramd),
    .done           (done),
    .running        (running),
    .ck             (ck),
    .stb            (stb),
    .inst_is_dir    (inst_is_dir),
    .inst_is_ind    (inst_is_ind),
    .inst_is_ppind  (inst_is_ppind),
    .fetch_pc2rama  (fetch_pc2rama),
    .fetch_ram_oe   (fetch_ram_oe),
    .fetch_ir_ck    (fetch_ir_ck),
    .fetch_pc_ck    (fetch_pc_ck),
    .defer_ir2rama  (defer_ir2rama),
    .defer_ram_oe   (defer_ram_oe),
    .defer_ld2inc   (defer_ld2inc),
    .defer_inc2ramd (defer_inc2ramd),
    .defer_ram_we   (defer_ram_we),
    .defer_ind_ck   (defer_ind_ck),
    .exec_err       (exec_err)
  );

  always #5 clk = ~clk;

  // {running, ck, stb, dir, ind, ppind, fetch x4, defer x6, exec_err}
  logic [26:0] obs_v;
  assign obs_v = {running, ck, stb, inst_is_dir, inst_is_ind, inst_is_ppind,
                  fetch_pc2rama, fetch_ram_oe, fetch_ir_ck, fetch_pc_ck,
                  defer_ir2rama, defer_ram_oe, defer_ld2inc, defer_inc2ramd,
                  defer_ram_we, defer_ind_ck, exec_err};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state: flags {dir, ind, ppind} and sticky error
  logic [2:0] m_flags;
  logic       m_err;

  function automatic logic [2:0] mode_of(input logic [11:0] iw);
    logic [6:0] addr;
    addr = iw[6:0];
    if (iw[11:9] >= 3'd6)                        return 3'b000;
    if (!iw[8])                                  return 3'b100;
    if (!iw[7] && addr >= 7'd8 && addr <= 7'd15) return 3'b001;
    return 3'b010;
  endfunction

  // Expected outputs on clock c of an instruction, counted from the first
  // FETCH clock: 2 FETCH clocks, ndef DEFER clocks, then EXEC clocks.
  function automatic logic [26:0] exp_at(input logic [2:0] newf, input int ndef, input int c);
    logic [5:0] ckv;
    logic [5:0] stbv;
    logic [5:0] de;
    logic [3:0] fe;
    logic [2:0] f;
    int d;
    int st;
    logic h;
    ckv  = 6'd0;
    stbv = 6'd0;
    de   = 6'd0;
    fe   = 4'd0;
    f    = (c < 2) ? m_flags : newf;
    if (c < 2) begin
      fe = {1'b1, 1'b1, c == 1, c == 1};
    end else if (c < 2 + ndef) begin
      d  = c - 2;
      st = d / 2 + 1;
      h  = (d % 2) == 1;
      if (st == 1) de = {1'b1, 1'b1, h & newf[0], 1'b0, 1'b0, h & newf[1]};
      else         de = {1'b1, 1'b0, 1'b0, 1'b1, h, h};
    end else begin
      d  = c - 2 - ndef;
      st = d / 2 + 1;
      h  = (d % 2) == 1;
      ckv[st-1]  = 1'b1;
      stbv[st-1] = h;
    end
    return {1'b1, ckv, stbv, f, fe, de, m_err};
  endfunction

  function automatic logic [26:0] halt_vec();
    return {1'b0, 6'd0, 6'd0, m_flags, 4'd0, 6'd0, m_err};
  endfunction

  // n HALT clocks with run_req low, then one HALT clock carrying run_req.
  task automatic idle_halt(input int n);
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      check_eq("halt_state", {5'd0, obs_v}, {5'd0, halt_vec()});
      run_req  = (i == n);
      halt_req = 1'($urandom);
      sstep    = 1'($urandom);
      done     = 1'($urandom);
      ramd     = 12'($urandom);
    end
  endtask

  // One instruction; k is the EXEC step whose first clock carries done,
  // 0 means done never comes and EXEC times out.
  task automatic do_instr(input logic [11:0] iw, input int k, input logic halt_end,
                          input logic sstep_end, input logic rr_end, output logic went_halt);
    logic [2:0] newf;
    int ndef;
    int nexec;
    int total;
    newf  = mode_of(iw);
    ndef  = newf[1] ? 2 : (newf[0] ? 4 : 0);
    nexec = (k == 0) ? 2 * MAX_STEPS : 2 * (k - 1) + 1;
    total = 2 + ndef + nexec;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      check_eq($sformatf("instr_%o_k%0d_clk%0d", iw, k, c), {5'd0, obs_v},
               {5'd0, exp_at(newf, ndef, c)});
      run_req  = 1'($urandom);
      halt_req = 1'($urandom);
      sstep    = 1'($urandom);
      done     = 1'($urandom);
      ramd     = 12'($urandom);
      if (c == 1) ramd = iw;
      if (c >= 2 + ndef) done = 1'b0;
      if (k != 0 && c == 2 + ndef + 2 * (k - 1)) done = 1'b1;
      if (c == total - 1) begin
        halt_req = halt_end;
        sstep    = sstep_end;
        run_req  = rr_end;
      end
    end
    m_flags   = newf;
    if (k == 0) m_err = 1'b1;
    went_halt = halt_end | (sstep_end & ~rr_end);
  endtask

  task automatic instr_then(input logic [11:0] iw, input int k, input logic halt_end,
                            input logic sstep_end, input logic rr_end);
    logic gh;
    do_instr(iw, k, halt_end, sstep_end, rr_end, gh);
    if (gh) idle_halt($urandom_range(0, 2));
  endtask

  initial begin
    logic [11:0] iw;
    logic [2:0]  nf;
    rst_n    = 1'b0;
    run_req  = 1'b0;
    halt_req = 1'b0;
    sstep    = 1'b0;
    ramd     = 12'd0;
    done     = 1'b0;
    m_flags  = 3'd0;
    m_err    = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("reset_outputs", {5'd0, obs_v}, 32'd0);
    rst_n = 1'b1;
    idle_halt(2);

    // Directed cases
    instr_then(12'o0100, 2, 1'b0, 1'b0, 1'b0);    // direct AND, 5 clocks
    instr_then(12'o1410, 3, 1'b0, 1'b0, 1'b0);    // TAD I 0010 autoindex
    instr_then(12'o5600, 1, 1'b0, 1'b0, 1'b0);    // JMP I, done on first EXEC clock
    instr_then(12'o7200, 0, 1'b0, 1'b0, 1'b0);    // op 7, timeout
    instr_then(12'o0100, 2, 1'b0, 1'b1, 1'b0);    // single step -> HALT
    instr_then(12'o1410, 2, 1'b0, 1'b1, 1'b0);    // second single step
    instr_then(12'o5600, 4, 1'b1, 1'b0, 1'b0);    // halt_req with done
    instr_then(12'o2017, MAX_STEPS, 1'b0, 1'b1, 1'b1); // sstep with run_req: keep going
    instr_then(12'o3000, 0, 1'b0, 1'b0, 1'b0);    // timeout while error already set

    // Randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      iw = 12'($urandom);
      if ($urandom_range(0, 3) == 0) iw = {3'($urandom_range(0, 5)), 1'b1, 1'b0, 4'b0001, 3'($urandom)};
      instr_then(iw, $urandom_range(0, MAX_STEPS),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0, 1'($urandom));
    end

    // Reset during the DEFER write step of an autoindex instruction
    instr_then(12'o0000, 1, 1'b1, 1'b0, 1'b0);
    nf = mode_of(12'o1410);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq($sformatf("pre_rst_clk%0d", c), {5'd0, obs_v}, {5'd0, exp_at(nf, 4, c)});
      run_req = 1'($urandom);
      done    = 1'($urandom);
      ramd    = (c == 1) ? 12'o1410 : 12'($urandom);
      if (c == 4) rst_n = 1'b0;
    end
    @(negedge clk);
    check_eq("mid_defer_reset", {5'd0, obs_v}, 32'd0);
    m_flags = 3'd0;
    m_err   = 1'b0;
    rst_n   = 1'b1;
    run_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("ram_we_after_reset", {31'd0, defer_ram_we}, 32'd0);
      check_eq("halt_after_reset", {5'd0, obs_v}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
